// File: rtl/fsm_trace_monitor.sv
// Runtime checker for the 2-bit control FSM: predicts each next state from the sampled
// inputs and flags illegal transitions and over-long dwell in non-idle states.
module fsm_trace_monitor #(
  parameter int unsigned DWELL_MAX = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       err_prev,
  output logic [1:0]       err_state,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] s3_cnt
);

  localparam int unsigned DW = $clog2(DWELL_MAX + 2);
  localparam logic [DW-1:0] DwellTop = DW'(DWELL_MAX + 1);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [1:0] CodeTrans = 2'b01;
  localparam logic [1:0] CodeDwell = 2'b10;

  // Transition function of the monitored FSM.
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic xi, input logic yi);
    logic [1:0] n;
    case (s)
      S0:      n = xi ? S1 : S0;
      S1:      n = xi ? S0 : (yi ? S3 : S1);
      S2:      n = (~(xi | yi)) ? S3 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  logic [1:0]       prev_s_q;
  logic             px_q, py_q, primed_q;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             err_q;
  logic [1:0]       err_code_q, err_prev_q, err_state_q;
  logic [CNT_W-1:0] trans_cnt_q, s3_cnt_q;

  logic [1:0] cur;
  logic       changed, trans_err, dwell_err;

  always_comb begin
    cur       = {a, b};
    changed   = (cur != prev_s_q);
    trans_err = primed_q && (next_state(prev_s_q, px_q, py_q) != cur);
    if (changed || (cur == S0)) begin
      dwell_d = DW'(1);
    end else if (dwell_q == DwellTop) begin
      dwell_d = DwellTop;
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
    dwell_err = (dwell_d == DwellTop) && (cur != S0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_s_q    <= S0;
      px_q        <= 1'b0;
      py_q        <= 1'b0;
      primed_q    <= 1'b0;
      dwell_q     <= DW'(1);
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      err_prev_q  <= 2'b00;
      err_state_q <= 2'b00;
      trans_cnt_q <= '0;
      s3_cnt_q    <= '0;
    end else begin
      prev_s_q <= cur;
      px_q     <= x;
      py_q     <= y;
      primed_q <= 1'b1;
      dwell_q  <= dwell_d;

      // Clear beats a simultaneous new error; persistent conditions re-fire next cycle.
      if (clr) begin
        err_q       <= 1'b0;
        err_code_q  <= 2'b00;
        err_prev_q  <= 2'b00;
        err_state_q <= 2'b00;
      end else if (!err_q && (trans_err || dwell_err)) begin
        err_q       <= 1'b1;
        err_code_q  <= trans_err ? CodeTrans : CodeDwell;
        err_prev_q  <= prev_s_q;
        err_state_q <= cur;
      end

      if (primed_q && changed && (trans_cnt_q != '1)) begin
        trans_cnt_q <= trans_cnt_q + 1'b1;
      end
      if (primed_q && (cur == S3) && (prev_s_q != S3) && (s3_cnt_q != '1)) begin
        s3_cnt_q <= s3_cnt_q + 1'b1;
      end
    end
  end

  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_prev  = err_prev_q;
  assign err_state = err_state_q;
  assign trans_cnt = trans_cnt_q;
  assign s3_cnt    = s3_cnt_q;

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// Directed bench for fsm_trace_monitor: legal walk, illegal entry, dwell timeout, sticky/clear,
// counter saturation (narrow instance) and reset in the middle of a dwell.
module tb_fsm_trace_monitor;

  logic clk = 1'b0;
  logic rst_n, x, y, a, b, clr;

  logic       err, err2;
  logic [1:0] err_code, err_prev, err_state, ec2, ep2, es2;
  logic [7:0] trans_cnt, s3_cnt;
  logic [1:0] tc2, s32;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fsm_trace_monitor #(.DWELL_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .a(a), .b(b), .clr(clr),
    .err(err), .err_code(err_code), .err_prev(err_prev), .err_state(err_state),
    .trans_cnt(trans_cnt), .s3_cnt(s3_cnt)
  );

  fsm_trace_monitor #(.DWELL_MAX(15), .CNT_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .a(a), .b(b), .clr(clr),
    .err(err2), .err_code(ec2), .err_prev(ep2), .err_state(es2),
    .trans_cnt(tc2), .s3_cnt(s32)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present state s and inputs x/y for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic [1:0] s, input logic xi, input logic yi);
    {a, b} = s;
    x = xi;
    y = yi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic chk_err(input string tag, input logic e, input logic [1:0] c,
                         input logic [1:0] p, input logic [1:0] s);
    chk({tag, "_err"}, {7'd0, err}, {7'd0, e});
    chk({tag, "_code"}, {6'd0, err_code}, {6'd0, c});
    chk({tag, "_prev"}, {6'd0, err_prev}, {6'd0, p});
    chk({tag, "_state"}, {6'd0, err_state}, {6'd0, s});
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b0; y = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;

    // Reset values
    do_reset();
    chk_err("rst", 1'b0, 2'b00, 2'b00, 2'b00);
    chk("rst_trans", trans_cnt, 8'd0);
    chk("rst_s3", s3_cnt, 8'd0);

    // Legal walk S0->S1->S3->S0
    cyc(2'b00, 1'b1, 1'b0);            // priming edge
    cyc(2'b01, 1'b0, 1'b1);
    chk("walk1_err", {7'd0, err}, 8'd0);
    cyc(2'b11, 1'b0, 1'b0);
    chk("walk2_err", {7'd0, err}, 8'd0);
    chk("walk2_s3", s3_cnt, 8'd1);
    cyc(2'b00, 1'b0, 1'b0);
    chk("walk3_err", {7'd0, err}, 8'd0);
    chk("walk_trans", trans_cnt, 8'd3);
    chk("walk_s3", s3_cnt, 8'd1);

    // Forced illegal entry into S2
    cyc(2'b00, 1'b0, 1'b0);
    chk("pre_ill_err", {7'd0, err}, 8'd0);
    cyc(2'b10, 1'b0, 1'b0);
    chk_err("ill", 1'b1, 2'b01, 2'b00, 2'b10);
    chk("ill_trans", trans_cnt, 8'd4);

    // Second error (f(S2,0,0)=S3, observed S1) must not disturb captured fields
    cyc(2'b01, 1'b0, 1'b0);
    chk_err("sticky", 1'b1, 2'b01, 2'b00, 2'b10);
    chk("sticky_trans", trans_cnt, 8'd5);

    clr = 1'b1;
    cyc(2'b01, 1'b0, 1'b0);
    clr = 1'b0;
    chk_err("clr", 1'b0, 2'b00, 2'b00, 2'b00);
    chk("clr_trans", trans_cnt, 8'd5);
    chk("clr_s3", s3_cnt, 8'd1);

    // Dwell timeout in S1
    do_reset();
    cyc(2'b00, 1'b1, 1'b0);            // priming edge
    for (int i = 1; i <= 15; i++) begin
      cyc(2'b01, 1'b0, 1'b0);
      if (i == 1 || i == 14) chk("dwell_early_err", {7'd0, err}, 8'd0);
    end
    chk("dwell15_err", {7'd0, err}, 8'd0);
    cyc(2'b01, 1'b0, 1'b0);            // 16th sample
    chk_err("dwell16", 1'b1, 2'b10, 2'b01, 2'b01);

    // Clear while the dwell condition persists: cleared, then re-detected
    clr = 1'b1;
    cyc(2'b01, 1'b0, 1'b0);
    clr = 1'b0;
    chk("dwell_clr_err", {7'd0, err}, 8'd0);
    cyc(2'b01, 1'b0, 1'b0);
    chk_err("dwell_redo", 1'b1, 2'b10, 2'b01, 2'b01);

    // Transition and dwell errors together: transition code wins
    clr = 1'b1;
    cyc(2'b01, 1'b1, 1'b0);            // px=1 registered, so f(S1)=S0 next edge
    clr = 1'b0;
    chk("both_clr_err", {7'd0, err}, 8'd0);
    cyc(2'b01, 1'b0, 1'b0);
    chk_err("both", 1'b1, 2'b01, 2'b01, 2'b01);

    // Saturation on the CNT_W=2 instance
    do_reset();
    cyc(2'b00, 1'b1, 1'b0);            // priming edge
    cyc(2'b01, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b0);
    chk("sat_mid", {6'd0, tc2}, 8'd2);
    cyc(2'b01, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b01, 1'b1, 1'b0);
    chk("sat_tc2", {6'd0, tc2}, 8'd3);
    chk("sat_wide", trans_cnt, 8'd5);
    chk("sat_err2", {7'd0, err2}, 8'd0);
    cyc(2'b00, 1'b1, 1'b0);
    chk("sat_hold", {6'd0, tc2}, 8'd3);

    // Reset in the middle of a dwell
    do_reset();
    cyc(2'b00, 1'b1, 1'b0);            // priming edge
    for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0, 1'b0);
    chk("mid_pre_err", {7'd0, err}, 8'd0);
    rst_n = 1'b0;
    cyc(2'b01, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2'b01, 1'b0, 1'b0);            // first post-reset edge: prime only
    chk("mid_noprime_err", {7'd0, err}, 8'd0);
    chk("mid_noprime_trans", trans_cnt, 8'd0);
    for (int i = 2; i <= 15; i++) cyc(2'b01, 1'b0, 1'b0);
    chk("mid15_err", {7'd0, err}, 8'd0);
    chk("mid15_trans", trans_cnt, 8'd0);
    cyc(2'b01, 1'b0, 1'b0);
    chk_err("mid16", 1'b1, 2'b10, 2'b01, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
